uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity modes
// and the three mid-bit sample positions used by the majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // The vote window straddles the bit centre by one tick on either side.
    localparam int VOTE_BEFORE = 1;
    localparam int VOTE_AFTER  = 1;

    function automatic int vote_first(input int ovs);
        return ovs / 2 - VOTE_BEFORE;
    endfunction

    function automatic int vote_mid(input int ovs);
        return ovs / 2;
    endfunction

    function automatic int vote_last(input int ovs);
        return ovs / 2 + VOTE_AFTER;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider that produces a one-cycle sample tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with majority-vote bit sampling, optional parity,
// 1 or 2 stop bits and a valid/ready output register with overrun detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OVS       = 16,
    parameter int DIV       = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SCW = $clog2(OVS);
    localparam logic [SCW-1:0] S_FIRST = SCW'(vote_first(OVS));
    localparam logic [SCW-1:0] S_MID   = SCW'(vote_mid(OVS));
    localparam logic [SCW-1:0] S_LAST  = SCW'(vote_last(OVS));
    localparam logic [SCW-1:0] S_END   = SCW'(OVS - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam parity_t PMODE = parity_t'(2'(PARITY));

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 tick;
    state_t               state;
    logic [SCW-1:0]       sample_cnt;
    logic [3:0]           bit_cnt;
    logic                 vote0;
    logic                 vote1;
    logic                 vote;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_err_r;
    logic                 frame_err_r;
    logic                 armed;
    logic                 frame_done;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign vote       = majority3(vote0, vote1, rx_sync);
    assign frame_done = tick && (state == ST_STOP) && (sample_cnt == S_LAST)
                        && (bit_cnt == LAST_STOP);

    // sample_cnt holds the index of the tick being processed; the start-detect
    // tick is index 0, so the first tick seen in START is index 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            vote0       <= 1'b0;
            vote1       <= 1'b0;
            shift_reg   <= '0;
            par_acc     <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            armed       <= 1'b1;
        end else if (tick) begin
            if (state == ST_IDLE) begin
                if (rx_sync) begin
                    armed <= 1'b1;
                end else if (armed) begin
                    state       <= ST_START;
                    busy        <= 1'b1;
                    sample_cnt  <= SCW'(1);
                    bit_cnt     <= '0;
                    par_acc     <= 1'b0;
                    par_err_r   <= 1'b0;
                    frame_err_r <= 1'b0;
                end
            end else begin
                sample_cnt <= (sample_cnt == S_END) ? '0 : sample_cnt + 1'b1;
                if (sample_cnt == S_FIRST) vote0 <= rx_sync;
                if (sample_cnt == S_MID)   vote1 <= rx_sync;
                case (state)
                    ST_START: begin
                        if (sample_cnt == S_LAST && vote) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (sample_cnt == S_END) begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (sample_cnt == S_LAST) begin
                            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                            par_acc   <= par_acc ^ vote;
                        end
                        if (sample_cnt == S_END) begin
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (sample_cnt == S_LAST) begin
                            par_err_r <= (PMODE == PAR_ODD) ? ~(par_acc ^ vote)
                                                            : (par_acc ^ vote);
                        end
                        if (sample_cnt == S_END) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Leave at mid-bit of the last stop bit so a following start edge is caught.
                        if (sample_cnt == S_LAST) begin
                            if (!vote) begin
                                frame_err_r <= 1'b1;
                                armed       <= 1'b0;
                            end
                            if (bit_cnt == LAST_STOP) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        if (sample_cnt == S_END) bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A held, unacknowledged word wins over a newly completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end else begin
                    data       <= shift_reg;
                    parity_err <= par_err_r;
                    frame_err  <= frame_err_r | ~vote;
                    valid      <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, both DIV=4, OVS=16.
module tb_uart_rx;

    localparam int BIT_CYC = 64;
    localparam int NVEC    = 7;

    typedef struct {
        logic       par_dut;
        logic [7:0] byte_val;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, ovr_a, ovr_b, busy_a, busy_b;
    logic sel = 1'b0;
    logic [7:0] m_data;
    logic m_valid, m_pe, m_fe;
    int checks = 0;
    int failures = 0;
    int ovr_count = 0;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    always @(negedge clk) if (ovr_a) ovr_count <= ovr_count + 1;

    assign m_data  = sel ? data_b  : data_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_pe    = sel ? pe_b    : pe_a;
    assign m_fe    = sel ? fe_b    : fe_a;

    uart_rx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVS(16), .DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVS(16), .DIV(4)) u_par (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int cycles);
        if (sel) rx_b = b; else rx_a = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] val, input logic par_en, input logic par_bit,
                              input logic stop_bit, input int stop_cycles);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(val[i], BIT_CYC);
        if (par_en) drive_bit(par_bit, BIT_CYC);
        drive_bit(stop_bit, stop_cycles);
    endtask

    task automatic applyStimulus(input vec_t v);
        sel = v.par_dut;
        send_frame(v.byte_val, v.par_dut, v.par_bit, v.stop_bit, BIT_CYC);
        drive_bit(1'b1, 16);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (m_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 16'(m_valid), 16'h1);
    endtask

    task automatic ack(input string name);
        if (sel) ready_b = 1'b1; else ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
        checkOutput(name, 16'(m_valid), 16'h0);
    endtask

    task automatic check_word(input string name, input logic [7:0] d, input logic pe, input logic fe);
        wait_valid({name, "_valid"});
        checkOutput({name, "_data"}, 16'(m_data), 16'(d));
        checkOutput({name, "_perr"}, 16'(m_pe), 16'(pe));
        checkOutput({name, "_ferr"}, 16'(m_fe), 16'(fe));
    endtask

    initial begin
        logic hold_ok;
        logic busy_seen;
        logic valid_seen;
        int   ovr_before;
        logic [7:0] mid_val;

        // par_dut, byte, parity bit, stop bit, expected data, perr, ferr
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 16'(valid_a), 16'h0);
        checkOutput("rst_busy", 16'(busy_a), 16'h0);
        checkOutput("rst_data", 16'(data_a), 16'h0);
        checkOutput("rst_overrun", 16'(ovr_a), 16'h0);
        rst_n = 1'b1;
        repeat (BIT_CYC) @(negedge clk);

        // 0xA5 held for 100 cycles without ready
        sel = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT_CYC);
        check_word("a5", 8'hA5, 1'b0, 1'b0);
        hold_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (valid_a !== 1'b1 || data_a !== 8'hA5) hold_ok = 1'b0;
        end
        checkOutput("a5_hold", 16'(hold_ok), 16'h1);
        ack("a5_ack");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            check_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
            ack($sformatf("vec%0d_ack", i));
        end

        // Short low glitch: false start, no output
        sel = 1'b0;
        busy_seen = 1'b0;
        valid_seen = 1'b0;
        rx_a = 1'b0;
        for (int i = 0; i < 2 * BIT_CYC; i++) begin
            if (i == 16) rx_a = 1'b1;
            @(negedge clk);
            if (busy_a === 1'b1) busy_seen = 1'b1;
            if (valid_a === 1'b1) valid_seen = 1'b1;
        end
        checkOutput("glitch_busy_seen", 16'(busy_seen), 16'h1);
        checkOutput("glitch_busy_end", 16'(busy_a), 16'h0);
        checkOutput("glitch_no_valid", 16'(valid_seen), 16'h0);

        // Back-to-back frames with no consumer: second one is dropped
        ovr_before = ovr_count;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, BIT_CYC);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, BIT_CYC);
        drive_bit(1'b1, 16);
        check_word("ovr", 8'h11, 1'b0, 1'b0);
        checkOutput("ovr_pulses", 16'(ovr_count - ovr_before), 16'h1);
        ack("ovr_ack");
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, BIT_CYC);
        drive_bit(1'b1, 16);
        check_word("after_ovr", 8'h33, 1'b0, 1'b0);
        ack("after_ovr_ack");

        // Break condition: stop bit low, line held low for 3 bit times
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, BIT_CYC);
        check_word("brk", 8'h5A, 1'b0, 1'b1);
        ack("brk_ack");
        busy_seen = 1'b0;
        repeat (2 * BIT_CYC - 1) begin
            @(negedge clk);
            if (busy_a === 1'b1) busy_seen = 1'b1;
        end
        checkOutput("brk_no_restart", 16'(busy_seen), 16'h0);
        drive_bit(1'b1, 2 * BIT_CYC);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, BIT_CYC);
        drive_bit(1'b1, 16);
        check_word("post_brk", 8'h0F, 1'b0, 1'b0);
        ack("post_brk_ack");

        // Reset asserted half way through data bit 3
        mid_val = 8'hC3;
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 3; i++) drive_bit(mid_val[i], BIT_CYC);
        drive_bit(mid_val[3], BIT_CYC / 2);
        checkOutput("mid_busy_pre", 16'(busy_a), 16'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 16'(busy_a), 16'h0);
        checkOutput("mid_rst_valid", 16'(valid_a), 16'h0);
        checkOutput("mid_rst_data", 16'(data_a), 16'h0);
        checkOutput("mid_rst_perr", 16'(pe_a), 16'h0);
        checkOutput("mid_rst_ferr", 16'(fe_a), 16'h0);
        checkOutput("mid_rst_overrun", 16'(ovr_a), 16'h0);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, BIT_CYC);
        drive_bit(1'b1, 16);
        check_word("post_rst", 8'h3C, 1'b0, 1'b0);
        ack("post_rst_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
